fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
// - Parametrised successor to the fixed-mux forwarding path: it tracks in-flight register writes from D onward.
// - Per D-stage read port, it selects the youngest producer value (or the register-file value) and raises a stall when that producer's result is not produced yet.
// - Sits between the decode stage and the E..W stage datapaths, and replaces the hand-coded CDRs/CDRt/CEA/CEB select generation.
// PARAMETERS
// - DW      32  data width
// - AW      5   register address width; address 0 is hard-zero and never forwarded
// - NSTAGE  3   tracked stages after D (0=E, 1=M, 2=W)
// - NRD     2   number of read ports in D
// - CW      32  stall performance counter width
// PORTS
// - clk         in   1            rising-edge clock
// - rst_n       in   1            asynchronous, active-low reset
// - hold        in   1            external freeze (e.g. mul busy); all tracking stages keep their contents
// - flush       in   1            kill the instruction leaving D; a bubble enters stage 0
// - iss_valid   in   1            D holds an instruction that writes a register
// - iss_dst     in   AW           destination register of the D instruction
// - iss_rdy     in   2            first stage index at which its result is valid (ALU=0, load=1, jal=0)
// - rd_addr     in   NRD*AW       D read addresses, port p at [p*AW +: AW]
// - rf_data     in   NRD*DW       register-file read data per port
// - stg_data    in   NSTAGE*DW    result currently held in stage k, at [k*DW +: DW]
// - rd_data     out  NRD*DW       forwarded operand per port
// - rd_sel      out  NRD*2        per port: 0=rf, else 1+k of the selected stage (debug/trace)
// - stall       out  1            D must hold; a bubble is injected into stage 0
// - stall_cnt   out  CW           saturating count of cycles with stall=1
// BEHAVIOUR
// - State: per stage k, {v[k], dst[k], rdy[k]}; a stage matches port p when v=1, dst==rd_addr_p, and rd_addr_p!=0.
// - Priority: the lowest k that matches wins (youngest producer). If no stage matches, rd_data_p=rf_data_p and sel=0.
// - The winning stage is ready when k>=rdy[k]. Ready: rd_data_p=stg_data[k] and sel=k+1. Not ready: stall=1 and rd_data_p=rf_data_p (don't-care).
// - Timing: forwarding and stall are combinational from the current state and inputs. Tracking updates on the clock edge (1-cycle latency).
// - Advance (hold=0): stage k+1 <= stage k. The oldest entry retires with no write-back modelled; the RF is not write-through, so W forwarding is required.
// - Stage 0 <= {iss_valid & ~stall & ~flush, iss_dst, iss_rdy}. stall or flush inserts a bubble (v=0).
// - hold=1: every stage keeps its contents and stall_cnt does not count. stall is still computed, so D stays held.
// - hold has priority over flush; flush has priority over stall. A flush during hold is ignored, and the caller re-asserts it.
// - iss_dst==0: the entry is inserted with v=0.
// - iss_rdy>=NSTAGE: illegal; the entry is treated as ready at stage NSTAGE-1.
// - stall_cnt increments when stall=1 and hold=0, and saturates at all-ones.
// - Reset (asynchronous, rst_n=0): all v=0, dst=0, rdy=0, stall_cnt=0.
//   During reset: stall=0, rd_data=rf_data, rd_sel=0.
//   Asserting reset mid-operation drops all in-flight tracking on the next evaluation, with no residual stall.
// - Multiple ports matching the same stage are resolved independently; stall is the OR of all ports.
// STRUCTURE
// - Shared package cpu_pkg: localparam RDY_ALU=0, RDY_LOAD=1; REG_ZERO=0; the sel encoding constants.
// - Sub-module fwd_port_sel (one instance per read port, generate loop):
//   - Inputs: stage table and stg_data. Outputs: rd_data_p, sel_p, stall_p.
//   - Purely combinational priority encoder over NSTAGE.
// - Top level: stage register shift chain, stall OR-reduce, stall counter.
// TESTING
// - 1. Reset: rst_n=0 with rf_data={0x11,0x22} -> rd_data={0x11,0x22}, stall=0, stall_cnt=0.
//   Release reset and issue dst=8 rdy=0 -> next cycle rd_addr0=8 with stg_data[0]=0xA5 -> rd_data0=0xA5, sel=1, stall=0.
// - 2. Load-use: issue dst=9 rdy=1, then next cycle rd_addr1=9 -> stall=1 for one cycle and a bubble appears in stage 0.
//   Following cycle: rd_data1=stg_data[1]=0x77, sel=2, stall_cnt=1.
// - 3. Youngest wins: dst=5 in stages 2 and 0 (stg_data 0x100/0x300) -> rd_addr0=5 gives 0x300, sel=1.
//   Reading r0 with v0 entries present -> rf value, sel=0.
// - 4. Hold: with a load pending in stage 0, hold=1 for 3 cycles -> stage table unchanged, stall stays 1, stall_cnt unchanged.
//   Release hold -> progression resumes.
// - 5. Flush: iss_valid=1 dst=3 with flush=1 -> stage 0 v=0, and a later read of r3 is taken from rf.
//   flush together with hold -> table frozen, flush dropped.
// - 6. Saturation and reset mid-op: with CW=4, force 20 stall cycles -> stall_cnt=4'hF.
//   Assert rst_n low asynchronously between edges -> stall falls immediately and all stages become v=0.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared constants and select encoding for the operand forwarding scoreboard
package fwd_scoreboard_pkg;
  localparam logic [1:0] RDY_ALU = 2'd0;
  localparam logic [1:0] RDY_LOAD = 2'd1;
  localparam int unsigned REG_ZERO = 0;
  typedef enum logic [1:0] {SEL_RF, SEL_E, SEL_M, SEL_W} sel_e;
  function automatic logic [1:0] sel_of(input int k);
    return 2'(k + 1);
  endfunction
endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: decode-side issue, read-port and forwarding bundle of the scoreboard
interface fwd_scoreboard_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NSTAGE = 3,
  parameter int NRD = 2,
  parameter int CW = 32
);
  logic hold;
  logic flush;
  logic iss_valid;
  logic [AW-1:0] iss_dst;
  logic [1:0] iss_rdy;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rf_data;
  logic [NSTAGE*DW-1:0] stg_data;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD*2-1:0] rd_sel;
  logic stall;
  logic [CW-1:0] stall_cnt;
  modport master (
    output hold, flush, iss_valid, iss_dst, iss_rdy, rd_addr, rf_data, stg_data,
    input rd_data, rd_sel, stall, stall_cnt
  );
  modport slave (
    input hold, flush, iss_valid, iss_dst, iss_rdy, rd_addr, rf_data, stg_data,
    output rd_data, rd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard_port_sel.sv
// fwd_scoreboard_port_sel: per read port, pick the youngest matching producer or fall back to the register file
module fwd_scoreboard_port_sel import fwd_scoreboard_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NSTAGE = 3
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf,
  input  logic [NSTAGE-1:0] v,
  input  logic [NSTAGE*AW-1:0] dst,
  input  logic [NSTAGE*2-1:0] rdy,
  input  logic [NSTAGE*DW-1:0] stg,
  output logic [DW-1:0] data,
  output logic [1:0] sel,
  output logic stall
);
  // scan oldest to youngest so the youngest match overwrites the rest
  always_comb begin
    data = rf;
    sel = SEL_RF;
    stall = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--)
      if (v[k] && dst[k*AW +: AW] == addr && addr != AW'(REG_ZERO)) begin
        data = k >= int'(rdy[k*2 +: 2]) ? stg[k*DW +: DW] : rf;
        sel = k >= int'(rdy[k*2 +: 2]) ? sel_of(k) : SEL_RF;
        stall = k < int'(rdy[k*2 +: 2]);
      end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writes after decode, forwards the youngest ready result and stalls on unready ones
module fwd_scoreboard import fwd_scoreboard_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NSTAGE = 3,
  parameter int NRD = 2,
  parameter int CW = 32
) (
  input logic clk,
  input logic rst_n,
  fwd_scoreboard_if.slave bus
);
  logic [NSTAGE-1:0] v;
  logic [NSTAGE*AW-1:0] dst;
  logic [NSTAGE*2-1:0] rdy;
  logic [NRD-1:0] stall_p;
  logic [CW-1:0] cnt;
  logic [1:0] rdy_in;
  logic stall;
  logic live;
  // an out-of-range ready stage behaves as ready at the last tracked stage
  assign rdy_in = int'(bus.iss_rdy) >= NSTAGE ? 2'(NSTAGE - 1) : bus.iss_rdy;
  assign live = bus.iss_valid & ~stall & ~bus.flush & (bus.iss_dst != AW'(REG_ZERO));
  assign stall = |stall_p;
  assign bus.stall = stall;
  assign bus.stall_cnt = cnt;
  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_scoreboard_port_sel #(.DW(DW), .AW(AW), .NSTAGE(NSTAGE)) u_sel (
      .addr(bus.rd_addr[p*AW +: AW]),
      .rf(bus.rf_data[p*DW +: DW]),
      .v(v),
      .dst(dst),
      .rdy(rdy),
      .stg(bus.stg_data),
      .data(bus.rd_data[p*DW +: DW]),
      .sel(bus.rd_sel[p*2 +: 2]),
      .stall(stall_p[p])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      dst <= '0;
      rdy <= '0;
      cnt <= '0;
    end else if (!bus.hold) begin
      v <= {v[NSTAGE-2:0], live};
      dst <= {dst[(NSTAGE-1)*AW-1:0], bus.iss_dst};
      rdy <= {rdy[(NSTAGE-1)*2-1:0], rdy_in};
      cnt <= (stall && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: scoreboard bench; a reference table predicts every D-cycle result, plus directed literal checks
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;
  localparam int DW = 32, AW = 5, NS = 3, NRD = 2, CW = 4;
  typedef struct {
    logic [63:0] data;
    logic [3:0] sel;
    logic stall;
    logic [3:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int step = 0;
  logic mv [NS];
  logic [4:0] md [NS];
  logic [1:0] mr [NS];
  logic [3:0] mcnt;
  logic mstall;
  exp_t sbq [$];

  fwd_scoreboard_if #(.DW(DW), .AW(AW), .NSTAGE(NS), .NRD(NRD), .CW(CW)) bus ();
  fwd_scoreboard #(.DW(DW), .AW(AW), .NSTAGE(NS), .NRD(NRD), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", tag, step, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
      mr[k] = '0;
    end
    mcnt = '0;
    mstall = 1'b0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [4:0] a;
    int hit;
    e.cnt = mcnt;
    e.stall = 1'b0;
    e.data = bus.rf_data;
    e.sel = '0;
    for (int p = 0; p < NRD; p++) begin
      a = bus.rd_addr[p*AW +: AW];
      hit = -1;
      for (int k = 0; k < NS; k++)
        if (hit < 0 && mv[k] && md[k] == a && a != 5'd0) hit = k;
      if (hit >= 0) begin
        if (hit >= int'(mr[hit])) begin
          e.data[p*DW +: DW] = bus.stg_data[hit*DW +: DW];
          e.sel[p*2 +: 2] = 2'(hit + 1);
        end else e.stall = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic stg(input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] s0);
    bus.stg_data = {s2, s1, s0};
  endtask

  task automatic drive(input logic h, input logic f, input logic iv, input logic [4:0] d, input logic [1:0] r);
    exp_t e;
    step++;
    bus.hold = h;
    bus.flush = f;
    bus.iss_valid = iv;
    bus.iss_dst = d;
    bus.iss_rdy = r;
    #1 sbq.push_back(predict());
    mstall = sbq[$].stall;
    #1 e = sbq.pop_front();
    chk("sb_data", bus.rd_data, e.data);
    chk("sb_sel", 64'(bus.rd_sel), 64'(e.sel));
    chk("sb_stall", 64'(bus.stall), 64'(e.stall));
    chk("sb_cnt", 64'(bus.stall_cnt), 64'(e.cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!bus.hold) begin
      if (mstall && mcnt != 4'hF) mcnt++;
      for (int k = NS - 1; k > 0; k--) begin
        mv[k] = mv[k-1];
        md[k] = md[k-1];
        mr[k] = mr[k-1];
      end
      mv[0] = bus.iss_valid && !mstall && !bus.flush && bus.iss_dst != 5'd0;
      md[0] = bus.iss_dst;
      mr[0] = bus.iss_rdy >= 2'(NS) ? 2'(NS - 1) : bus.iss_rdy;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog step %0d got timeout expected finish", step);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_dst = '0;
    bus.iss_rdy = '0;
    bus.rf_data = {32'h22, 32'h11};
    rd(0, 0);
    stg(0, 0, 0);
    #2;
    chk("rst_data", bus.rd_data, 64'h00000022_00000011);
    chk("rst_sel", 64'(bus.rd_sel), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 8, RDY_ALU);
    tick();
    stg(0, 0, 32'hA5);
    rd(8, 0);
    drive(0, 0, 0, 0, 0);
    chk("fwd_e_data", 64'(bus.rd_data[31:0]), 64'hA5);
    chk("fwd_e_sel", 64'(bus.rd_sel[1:0]), 64'd1);
    chk("fwd_e_stall", 64'(bus.stall), 64'd0);
    tick();
    rd(0, 0);
    drive(0, 0, 1, 9, RDY_LOAD);
    tick();
    rd(0, 9);
    drive(0, 0, 1, 10, RDY_ALU);
    chk("ldu_stall", 64'(bus.stall), 64'd1);
    tick();
    stg(0, 32'h77, 0);
    drive(0, 0, 1, 10, RDY_ALU);
    chk("ldu_data1", 64'(bus.rd_data[63:32]), 64'h77);
    chk("ldu_sel1", 64'(bus.rd_sel[3:2]), 64'd2);
    chk("ldu_nostall", 64'(bus.stall), 64'd0);
    chk("ldu_cnt", 64'(bus.stall_cnt), 64'd1);
    tick();
    rd(0, 0);
    drive(0, 0, 1, 5, RDY_ALU);
    tick();
    drive(0, 0, 1, 0, RDY_ALU);
    tick();
    drive(0, 0, 1, 5, RDY_ALU);
    tick();
    stg(32'h100, 32'h200, 32'h300);
    rd(5, 0);
    drive(0, 0, 0, 0, 0);
    chk("young_data", 64'(bus.rd_data[31:0]), 64'h300);
    chk("young_sel", 64'(bus.rd_sel[1:0]), 64'd1);
    chk("r0_data", 64'(bus.rd_data[63:32]), 64'h22);
    chk("r0_sel", 64'(bus.rd_sel[3:2]), 64'd0);
    tick();
    rd(0, 0);
    drive(0, 0, 1, 12, RDY_LOAD);
    tick();
    rd(12, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("hold_stall", 64'(bus.stall), 64'd1);
      chk("hold_cnt", 64'(bus.stall_cnt), 64'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("unhold_stall", 64'(bus.stall), 64'd1);
    tick();
    stg(0, 32'h1200, 0);
    drive(0, 0, 0, 0, 0);
    chk("unhold_data", 64'(bus.rd_data[31:0]), 64'h1200);
    chk("unhold_sel", 64'(bus.rd_sel[1:0]), 64'd2);
    chk("unhold_cnt", 64'(bus.stall_cnt), 64'd2);
    tick();
    rd(0, 0);
    drive(0, 1, 1, 3, RDY_ALU);
    tick();
    rd(3, 0);
    drive(0, 0, 0, 0, 0);
    chk("flush_data", 64'(bus.rd_data[31:0]), 64'h11);
    chk("flush_sel", 64'(bus.rd_sel[1:0]), 64'd0);
    tick();
    rd(0, 0);
    drive(0, 0, 1, 4, RDY_ALU);
    tick();
    drive(1, 1, 1, 3, RDY_ALU);
    tick();
    rd(4, 3);
    stg(0, 0, 32'h44);
    drive(0, 0, 0, 0, 0);
    chk("frz_data", 64'(bus.rd_data[31:0]), 64'h44);
    chk("frz_sel0", 64'(bus.rd_sel[1:0]), 64'd1);
    chk("frz_sel1", 64'(bus.rd_sel[3:2]), 64'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      rd(0, 0);
      drive(0, 0, 1, 13, RDY_LOAD);
      tick();
      rd(0, 13);
      drive(0, 0, 0, 0, 0);
      tick();
    end
    rd(0, 0);
    drive(0, 0, 0, 0, 0);
    chk("sat_cnt", 64'(bus.stall_cnt), 64'hF);
    tick();
    drive(0, 0, 1, 15, 2'd3);
    tick();
    rd(15, 0);
    drive(0, 0, 0, 0, 0);
    chk("ill_stall0", 64'(bus.stall), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("ill_stall1", 64'(bus.stall), 64'd1);
    tick();
    stg(32'hF15, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("ill_sel", 64'(bus.rd_sel[1:0]), 64'd3);
    chk("ill_data", 64'(bus.rd_data[31:0]), 64'hF15);
    tick();
    rd(0, 0);
    drive(0, 0, 1, 14, RDY_LOAD);
    tick();
    rd(14, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_stall", 64'(bus.stall), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(bus.stall), 64'd0);
    chk("mid_rst_data", bus.rd_data, 64'h00000022_00000011);
    chk("mid_rst_sel", 64'(bus.rd_sel), 64'd0);
    chk("mid_rst_cnt", 64'(bus.stall_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(14, 13);
    drive(0, 0, 0, 0, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
